// File: rtl/mem_reader_arb_pkg.sv
// Shared types and width helpers for the mem_reader arbiter.
package mem_reader_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    localparam int unsigned RESP_LAST_BIT = 0;

    // Request word is {addr, length}.
    function automatic int unsigned req_w(input int unsigned addr_w);
        return 2 * addr_w;
    endfunction

    // Response word is {data, length, last}.
    function automatic int unsigned resp_w(input int unsigned data_w, input int unsigned addr_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_reader_arbiter_if.sv
// Client-side and mem_reader-side req/resp channels of the arbiter.
// slave: arbiter view; master: clients plus mem_reader view.
interface mem_reader_arbiter_if #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned DSLX_DATA_W = 64,
    parameter int unsigned DSLX_ADDR_W = 16
);
    import mem_reader_arb_pkg::*;

    localparam int unsigned REQ_W  = req_w(DSLX_ADDR_W);
    localparam int unsigned RESP_W = resp_w(DSLX_DATA_W, DSLX_ADDR_W);

    logic [NUM_REQ-1:0]       up_req_vld;
    logic [NUM_REQ-1:0]       up_req_rdy;
    logic [NUM_REQ*REQ_W-1:0] up_req_data;
    logic [NUM_REQ-1:0]       up_resp_vld;
    logic [NUM_REQ-1:0]       up_resp_rdy;
    logic [RESP_W-1:0]        up_resp_data;
    logic                     mem_req_vld;
    logic                     mem_req_rdy;
    logic [REQ_W-1:0]         mem_req_data;
    logic                     mem_resp_vld;
    logic                     mem_resp_rdy;
    logic [RESP_W-1:0]        mem_resp_data;

    modport slave (
        input  up_req_vld, up_req_data, up_resp_rdy,
        input  mem_req_rdy, mem_resp_vld, mem_resp_data,
        output up_req_rdy, up_resp_vld, up_resp_data,
        output mem_req_vld, mem_req_data, mem_resp_rdy
    );

    modport master (
        output up_req_vld, up_req_data, up_resp_rdy,
        output mem_req_rdy, mem_resp_vld, mem_resp_data,
        input  up_req_rdy, up_resp_vld, up_resp_data,
        input  mem_req_vld, mem_req_data, mem_resp_rdy
    );

endinterface

// File: rtl/mem_reader_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit of req_i scanning from ptr_i upward, mod N.
// ptr_i tied to zero gives plain lowest-index priority.
module rr_pick #(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int unsigned cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_i) + k) % N;
            if (!found_o && req_i[IW'(cand)]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_reader_arbiter.sv
// Shares one mem_reader between NUM_REQ clients, granting whole transactions.
// Define MEM_READER_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module mem_reader_arbiter
    import mem_reader_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 3,
    parameter  int unsigned DSLX_DATA_W = 64,
    parameter  int unsigned DSLX_ADDR_W = 16,
    localparam int unsigned REQ_W       = req_w(DSLX_ADDR_W),
    localparam int unsigned RESP_W      = resp_w(DSLX_DATA_W, DSLX_ADDR_W),
    localparam int unsigned IDX_W       = idx_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_reader_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner
);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [REQ_W-1:0]  req_reg_q;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [REQ_W-1:0]  win_data;
    logic [RESP_W-1:0] resp_beat;
    logic              resp_xfer_last;

`ifdef MEM_READER_ARB_FIXED_PRIO_EN
    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (bus.up_req_vld),
        .ptr_i   ('0),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );
`else
    logic [IDX_W-1:0]  rr_ptr_q;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (bus.up_req_vld),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );
`endif

    // Mux the winning client's request word out of the flat bus.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                win_data = bus.up_req_data[i*REQ_W +: REQ_W];
            end
        end
    end

    assign resp_beat      = bus.mem_resp_data;
    assign resp_xfer_last = bus.mem_resp_vld && bus.mem_resp_rdy && resp_beat[RESP_LAST_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            req_reg_q <= '0;
`ifndef MEM_READER_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        req_reg_q <= win_data;
                        owner_q   <= pick_idx;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.mem_req_rdy) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A transaction ends only on last=1, whatever the requested length.
                    if (resp_xfer_last) begin
                        state_q  <= IDLE;
`ifndef MEM_READER_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.up_req_rdy   = (state_q == IDLE && pick_found && !rst)
                              ? (NUM_REQ'(1) << pick_idx) : '0;
    assign bus.mem_req_vld  = (state_q == SEND);
    assign bus.mem_req_data = req_reg_q;
    assign bus.up_resp_vld  = (state_q == WAIT && bus.mem_resp_vld)
                              ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.mem_resp_rdy = (state_q == WAIT) && bus.up_resp_rdy[owner_q];
    assign bus.up_resp_data = resp_beat;
    assign busy             = (state_q != IDLE);
    assign owner            = owner_q;

    // A request offered to mem_reader must hold until it is taken.
    property p_req_hold;
        @(posedge clk) disable iff (rst)
            bus.mem_req_vld && !bus.mem_req_rdy |=> bus.mem_req_vld && $stable(bus.mem_req_data);
    endproperty
    a_req_hold: assert property (p_req_hold);

    a_grant_onehot: assert property (@(posedge clk) $onehot0(bus.up_req_rdy));
    a_resp_onehot:  assert property (@(posedge clk) $onehot0(bus.up_resp_vld));

endmodule

// File: doc/mem_reader_arbiter.md
Name: mem_reader_arbiter

Overview:
- Shares one mem_reader instance between NUM_REQ client procs, e.g. the zstd frame header decoder, block header decoder and raw-block copier.
- Round-robin arbitration grants a whole transaction: one request, then every response beat up to and including the one with last=1.
- Sits between the clients and the mem_reader wrapper's req/resp channels. The ctrl channel is not arbitrated.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DSLX_DATA_W, 64, response data width
- DSLX_ADDR_W, 16, address/length width
- REQ_W, 2*DSLX_ADDR_W, request word {addr, length}; addr is MSBs
- RESP_W, DSLX_DATA_W+DSLX_ADDR_W+1, response word {data, length, last}; last is bit 0
- IDX_W, $clog2(NUM_REQ), requester index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- up_req_vld  in  NUM_REQ  per-client request valid
- up_req_rdy  out  NUM_REQ  per-client request ready
- up_req_data  in  NUM_REQ*REQ_W  client i occupies bits [i*REQ_W +: REQ_W]
- up_resp_vld  out  NUM_REQ  per-client response valid
- up_resp_rdy  in  NUM_REQ  per-client response ready
- up_resp_data  out  RESP_W  response word, broadcast to all clients
- mem_req_vld  out  1  to mem_reader req channel
- mem_req_rdy  in  1  from mem_reader req channel
- mem_req_data  out  REQ_W  to mem_reader req channel
- mem_resp_vld  in  1  from mem_reader resp channel
- mem_resp_rdy  out  1  to mem_reader resp channel
- mem_resp_data  in  RESP_W  from mem_reader resp channel
- busy  out  1  high while state is not IDLE
- owner  out  IDX_W  index of the current grant holder

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, rr_ptr=0, owner=0, req_reg=0. All vld/rdy outputs and busy are 0.
- All handshakes follow valid/ready: a transfer occurs on a cycle where both are 1. vld, once asserted, holds with data stable until the transfer.

State IDLE:
- Winner = first i with up_req_vld[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- up_req_rdy[winner]=1 combinationally; all other up_req_rdy bits are 0.
- On that transfer: req_reg <= up_req_data[winner], owner <= winner, state -> SEND.
- With no valid requests the block stays in IDLE.

State SEND:
- mem_req_vld=1, mem_req_data=req_reg.
- On mem_req_rdy: state -> WAIT.
- All up_req_rdy bits are 0.

State WAIT:
- up_resp_vld[owner]=mem_resp_vld; all other up_resp_vld bits are 0.
- mem_resp_rdy=up_resp_rdy[owner]; up_resp_rdy of non-owners is ignored.
- up_resp_data=mem_resp_data in every state (pure wire).
- On a resp transfer with mem_resp_data[0]=1: state -> IDLE, rr_ptr <= (owner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.

Latency and throughput:
- mem_req_vld rises the cycle after the client request transfer.
- Response path has zero added latency.
- After the last beat, IDLE may grant a new request in the next cycle. Minimum gap between mem_reader transactions is 2 cycles.

Boundary conditions:
- Zero-length request: forwarded unchanged; the arbiter waits for a beat with last=1 regardless of length.
- mem_resp_vld while in IDLE or SEND: mem_resp_rdy=0, so the beat is stalled, never dropped.
- Reset mid-transaction returns the block to IDLE. Upstream and mem_reader are reset together.

Optional Feature:
- Macro: MEM_READER_ARB_FIXED_PRIO_EN.
- Defined: winner = lowest index with valid; rr_ptr is neither used nor updated.
- Undefined (default): round-robin as described above.

Decomposition:
- Package mem_reader_arb_pkg holds:
  - state enum (IDLE=2'd0, SEND=2'd1, WAIT=2'd2)
  - RESP_LAST_BIT=0
  - REQ/RESP width helper functions
- One sub-module, rr_pick: combinational rotate-priority picker over NUM_REQ bits, returning winner index and found flag. It also serves fixed-priority mode with ptr=0.

Test Plan:
- Single client: client 1 sends {addr=0x0100, len=0x0018}; mem returns 3 beats, last on the 3rd. Expect mem_req_data=0x01000018 one cycle after accept, all 3 beats on up_resp_vld[1] only, then busy=0.
- Contention: clients 0, 1, 2 all valid from reset. Expect grant order 0,1,2,0 across four transactions, and rr_ptr wraps from 2 to 0.
- Backpressure: mem_req_rdy held low for 5 cycles in SEND, then up_resp_rdy[owner] toggled every other cycle. Expect req data stable throughout, no beat lost or duplicated, mem_resp_rdy mirroring the owner's ready.
- Non-owner ready: client 2 holds up_resp_rdy=1 while client 0 owns a transaction with up_resp_rdy=0. Expect mem_resp_rdy=0 and no transfer.
- Reset mid-WAIT: assert rst after the 1st of 4 beats. Next cycle expect busy=0, all rdy/vld outputs 0, rr_ptr=0.
- With MEM_READER_ARB_FIXED_PRIO_EN defined and clients 0 and 2 continuously valid: client 0 wins every grant and client 2 is never granted.
